// File: rtl/pe_array_seq.sv
// Tile sequencer for the 4x4 systolic PE array: clear, stream operands, flush, read back 16 results.
// Optional `PE_SEQ_RELU_EN`: clamps negative results to zero on the result stream.
module pe_array_seq #(
    parameter int K_W   = 8,
    parameter int DRAIN = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [K_W-1:0] k_len,
    output logic           busy,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    in_data,
    input  logic [31:0]    in_weight,
    output logic           pe_rst_n,
    output logic           pe_en,
    output logic [7:0]     pe_data0,
    output logic [7:0]     pe_data1,
    output logic [7:0]     pe_data2,
    output logic [7:0]     pe_data3,
    output logic [7:0]     pe_weight0,
    output logic [7:0]     pe_weight1,
    output logic [7:0]     pe_weight2,
    output logic [7:0]     pe_weight3,
    output logic [3:0]     pe_out_sel,
    input  logic [31:0]    pe_result,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    out_data,
    output logic [3:0]     out_idx,
    output logic           out_last,
    output logic           done,
    output logic [2:0]     dbg_state
);

    // Handshakes: a beat/result transfers on a rising clk edge where valid and ready are both 1.
    // in_ready is high only in FEED; out_valid only in OUT, holding data/idx until out_ready.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_FEED  = 3'd2,
        S_FLUSH = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    localparam int FW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    state_t         state;
    logic [K_W-1:0] beat_cnt;
    logic [FW-1:0]  flush_cnt;
    logic [3:0]     idx;
    logic           feed_act;
    logic [31:0]    res_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            idx       <= 4'd0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            pe_rst_n  <= 1'b0;
        end else begin
            done     <= 1'b0;
            pe_rst_n <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_CLR;
                        beat_cnt <= k_len;
                        busy     <= 1'b1;
                        pe_rst_n <= 1'b0;
                    end
                end
                S_CLR: begin
                    if (beat_cnt == '0) begin
                        state     <= S_FLUSH;
                        flush_cnt <= FW'(DRAIN - 1);
                    end else begin
                        state    <= S_FEED;
                        in_ready <= 1'b1;
                    end
                end
                S_FEED: begin
                    if (in_valid) begin
                        beat_cnt <= beat_cnt - K_W'(1);
                        if (beat_cnt == K_W'(1)) begin
                            state     <= S_FLUSH;
                            in_ready  <= 1'b0;
                            flush_cnt <= FW'(DRAIN - 1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state     <= S_OUT;
                        out_valid <= 1'b1;
                        idx       <= 4'd0;
                    end else begin
                        flush_cnt <= flush_cnt - FW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (idx == 4'd15) begin
                            state     <= S_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            idx       <= 4'd0;
                        end else begin
                            idx      <= idx + 4'd1;
                            out_last <= (idx == 4'd14);
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    idx       <= 4'd0;
                end
            endcase
        end
    end

    // Operands pass through only on an accepted beat; zeros otherwise so FLUSH and gaps feed nothing.
    assign feed_act   = (state == S_FEED) && in_valid;
    assign pe_en      = feed_act || (state == S_FLUSH);
    assign pe_data0   = feed_act ? in_data[7:0]     : 8'h00;
    assign pe_data1   = feed_act ? in_data[15:8]    : 8'h00;
    assign pe_data2   = feed_act ? in_data[23:16]   : 8'h00;
    assign pe_data3   = feed_act ? in_data[31:24]   : 8'h00;
    assign pe_weight0 = feed_act ? in_weight[7:0]   : 8'h00;
    assign pe_weight1 = feed_act ? in_weight[15:8]  : 8'h00;
    assign pe_weight2 = feed_act ? in_weight[23:16] : 8'h00;
    assign pe_weight3 = feed_act ? in_weight[31:24] : 8'h00;

    assign pe_out_sel = idx;
    assign out_idx    = idx;
    assign dbg_state  = state;

`ifdef PE_SEQ_RELU_EN
    assign res_val = pe_result[31] ? 32'd0 : pe_result;
`else
    assign res_val = pe_result;
`endif

    assign out_data = out_valid ? res_val : 32'd0;

endmodule

// File: tb/tb_pe_array_seq.sv
// Bench for pe_array_seq: a skewed 4x4 PE array model feeds pe_result; results checked
// against a plain sum-of-products reference computed from the accepted beats.
module tb_pe_array_seq;
    localparam int K_W   = 8;
    localparam int DRAIN = 7;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [K_W-1:0] k_len = '0;
    logic           busy;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [31:0]    in_data = '0;
    logic [31:0]    in_weight = '0;
    logic           pe_rst_n, pe_en;
    logic [7:0]     pe_data0, pe_data1, pe_data2, pe_data3;
    logic [7:0]     pe_weight0, pe_weight1, pe_weight2, pe_weight3;
    logic [3:0]     pe_out_sel;
    logic [31:0]    pe_result;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [31:0]    out_data;
    logic [3:0]     out_idx;
    logic           out_last, done;
    logic [2:0]     dbg_state;

    pe_array_seq #(.K_W(K_W), .DRAIN(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
        .pe_rst_n(pe_rst_n), .pe_en(pe_en),
        .pe_data0(pe_data0), .pe_data1(pe_data1), .pe_data2(pe_data2), .pe_data3(pe_data3),
        .pe_weight0(pe_weight0), .pe_weight1(pe_weight1),
        .pe_weight2(pe_weight2), .pe_weight3(pe_weight3),
        .pe_out_sel(pe_out_sel), .pe_result(pe_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- PE array model (output-stationary, operands skewed by i+j) ----------------
    logic [31:0] acc [16];
    logic [31:0] wh [8];
    logic [31:0] dh [8];
    logic [31:0] pe_w_vec, pe_d_vec;
    assign pe_w_vec  = {pe_weight3, pe_weight2, pe_weight1, pe_weight0};
    assign pe_d_vec  = {pe_data3, pe_data2, pe_data1, pe_data0};
    assign pe_result = acc[pe_out_sel];

    function automatic logic [31:0] byte_prod(input logic [7:0] a, input logic [7:0] b);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return 32'(sa * sb);
    endfunction

    function automatic logic [7:0] arr_w(input int dly, input int row);
        logic [31:0] v;
        v = (dly == 0) ? pe_w_vec : wh[dly-1];
        return v[8*row +: 8];
    endfunction

    function automatic logic [7:0] arr_d(input int dly, input int col);
        logic [31:0] v;
        v = (dly == 0) ? pe_d_vec : dh[dly-1];
        return v[8*col +: 8];
    endfunction

    always @(posedge clk) begin
        if (!pe_rst_n) begin
            for (int k = 0; k < 16; k++) acc[k] <= '0;
            for (int k = 0; k < 8; k++) begin
                wh[k] <= '0;
                dh[k] <= '0;
            end
        end else if (pe_en) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    acc[4*i+j] <= acc[4*i+j] + byte_prod(arr_w(i+j, i), arr_d(i+j, j));
            wh[0] <= pe_w_vec;
            dh[0] <= pe_d_vec;
            for (int k = 1; k < 8; k++) begin
                wh[k] <= wh[k-1];
                dh[k] <= dh[k-1];
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] beat_d[$];
    logic [31:0] beat_w[$];
    logic [31:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: result[4i+j] = sum over beats of signed(w_i) * signed(d_j), 32-bit wrap.
    task automatic build_expected();
        logic [31:0] sum;
        logic [31:0] w, d;
        exp_q.delete();
        for (int idx = 0; idx < 16; idx++) begin
            sum = '0;
            for (int b = 0; b < beat_d.size(); b++) begin
                w = beat_w[b];
                d = beat_d[b];
                sum = sum + byte_prod(w[8*(idx/4) +: 8], d[8*(idx%4) +: 8]);
            end
`ifdef PE_SEQ_RELU_EN
            if (sum[31]) sum = '0;
`endif
            exp_q.push_back(sum);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic gen_random(input int k);
        beat_d.delete();
        beat_w.delete();
        for (int b = 0; b < k; b++) begin
            beat_d.push_back($urandom);
            beat_w.push_back($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pe_rst_n"}, 32'(pe_rst_n), 32'd0);
        check_val({tag, "_ctl"}, {25'd0, pe_en, in_ready, out_valid, out_last, done, busy, 1'b0}, 32'd0);
        check_val({tag, "_opd"}, pe_d_vec | pe_w_vec, 32'd0);
        check_val({tag, "_sel"}, {24'd0, pe_out_sel, out_idx}, 32'd0);
    endtask

    task automatic pulse_start(input int k);
        start = 1'b1;
        k_len = K_W'(k);
        @(posedge clk); #1;
        start = 1'b0;
        check_val("clr_busy", 32'(busy), 32'd1);
        check_val("clr_pe_rst_n", 32'(pe_rst_n), 32'd0);
        check_val("clr_pe_en", 32'(pe_en), 32'd0);
        check_val("clr_in_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic feed(input logic [3:0] pat);
        int b = 0;
        int p = 0;
        int guard = 0;
        logic fire;
        while (b < beat_d.size() && guard < 4000) begin
            if (in_ready) begin
                in_valid = pat[p%4];
                p++;
            end else begin
                in_valid = 1'b1;
            end
            in_data = beat_d[b];
            in_weight = beat_w[b];
            #1;
            if (in_ready && !in_valid) check_val("gap_pe_en", 32'(pe_en), 32'd0);
            if (in_ready && in_valid) begin
                check_val("pass_data", pe_d_vec, beat_d[b]);
                check_val("pass_weight", pe_w_vec, beat_w[b]);
            end
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) b++;
            guard++;
        end
        if (guard >= 4000) check_val("feed_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
        in_data = '0;
        in_weight = '0;
    endtask

    task automatic wait_out();
        int lat = 0;
        int en_cnt = 0;
        while (!out_valid && lat < 100) begin
            if (pe_en) en_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        check_val("out_latency", 32'(lat), 32'(DRAIN));
        check_val("flush_en_cycles", 32'(en_cnt), 32'(DRAIN));
    endtask

    task automatic drain_out(input int bp_idx, input int bp_len, input bit poke);
        int n = 0;
        int hold = 0;
        int guard = 0;
        logic fire;
        while (n < 16 && guard < 2000) begin
            out_ready = !(n == bp_idx && hold < bp_len);
            if (n == bp_idx && hold < bp_len) hold++;
            start = poke && (n == 3);
            k_len = K_W'(5);
            #1;
            check_val("out_valid", 32'(out_valid), 32'd1);
            check_val("out_idx", 32'(out_idx), 32'(n));
            check_val("out_data", out_data, exp_q[n]);
            check_val("out_last", 32'(out_last), 32'(n == 15));
            fire = out_valid && out_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (fire) n++;
            guard++;
        end
        if (guard >= 2000) check_val("out_timeout", 32'd1, 32'd0);
        out_ready = 1'b0;
        check_val("done_pulse", 32'(done), 32'd1);
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("idle_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check_val("done_clear", 32'(done), 32'd0);
        check_val("no_restart", 32'(busy), 32'd0);
    endtask

    task automatic run_tile(input logic [3:0] pat, input int bp_idx, input int bp_len, input bit poke);
        build_expected();
        pulse_start(beat_d.size());
        if (beat_d.size() == 0) begin
            @(posedge clk); #1;
        end
        feed(pat);
        wait_out();
        drain_out(bp_idx, bp_len, poke);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("rst_release_pe_rst_n", 32'(pe_rst_n), 32'd1);
        check_val("rst_release_busy", 32'(busy), 32'd0);

        // K=1 outer product
        beat_d = '{32'h04030201};
        beat_w = '{32'h281E140A};
        run_tile(4'b1111, 99, 0, 1'b0);

        // K=4 identity weights select each data beat as a row
        beat_d.delete();
        beat_w.delete();
        for (int k = 0; k < 4; k++) begin
            beat_w.push_back(32'h1 << (8*k));
            beat_d.push_back({8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)});
        end
        run_tile(4'b1111, 99, 0, 1'b0);

        // K=3 gap-free then with 1,0,0,1 valid pattern
        gen_random(3);
        run_tile(4'b1111, 99, 0, 1'b0);
        run_tile(4'b1001, 99, 0, 1'b0);

        // backpressure at idx 7 for 5 cycles
        gen_random(5);
        run_tile(4'b1111, 7, 5, 1'b0);

        // back-to-back tiles, start poked during the first OUT
        gen_random(4);
        run_tile(4'b1111, 99, 0, 1'b1);
        gen_random(2);
        run_tile(4'b1111, 99, 0, 1'b0);

        // reset during FLUSH aborts the tile
        gen_random(2);
        pulse_start(2);
        feed(4'b1111);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        beat_d = '{32'h03030303};
        beat_w = '{32'h02020202};
        run_tile(4'b1111, 99, 0, 1'b0);

        // negative products (clamped when ReLU is built in)
        beat_d = '{32'hFFFFFFFF};
        beat_w = '{32'h01010101};
        run_tile(4'b1111, 99, 0, 1'b0);

        // K=0 tile
        gen_random(0);
        run_tile(4'b1111, 99, 0, 1'b0);

        // randomized tiles
        for (int t = 0; t < 6; t++) begin
            gen_random($urandom_range(0, 12));
            run_tile(4'($urandom_range(1, 15)), $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // maximum tile length
        gen_random(255);
        run_tile(4'b1111, 15, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
